// File: rtl/inj_stream_src.sv
// rtl/inj_stream_src.sv - memory-fed packet stream source for a Hermes credit port
// Optional checksum output enabled by defining INJ_STREAM_SRC_CHECKSUM_EN.
module inj_stream_src #(
    parameter int ADDR_W        = 24,
    parameter int FIFO_DEPTH    = 4,
    parameter int MAX_PKT_WORDS = 4096
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    output logic              mem_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [31:0]       mem_data_i,
    output logic              src_tx_o,
    input  logic              src_credit_i,
    output logic [31:0]       src_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [31:0]       flit_cnt_o
`ifdef INJ_STREAM_SRC_CHECKSUM_EN
    ,
    output logic [31:0]       csum_o
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REM_W = $clog2(MAX_PKT_WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_RD,
        S_LEN_WAIT,
        S_PAYLOAD,
        S_DRAIN,
        S_ERR
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_ptr;
    logic [REM_W-1:0]  remaining;
    logic              rd_pending;
    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;

    logic fifo_empty;
    logic len_zero;
    logic len_bad;
    logic push_len;
    logic xfer;
    logic pop;
    logic bypass;
    logic push;
    logic payload_rd;

    assign fifo_empty = (fifo_cnt == '0);
    assign len_zero   = (mem_data_i == 32'd0);
    assign len_bad    = (mem_data_i > 32'(MAX_PKT_WORDS));
    assign push_len   = (state == S_LEN_WAIT) && !len_zero && !len_bad;

    // A payload word returning into an empty FIFO is offered straight away so
    // a credit-always sink sees one flit per cycle behind the LEN flit.
    assign src_tx_o   = !fifo_empty || rd_pending;
    assign xfer       = src_tx_o && src_credit_i;
    assign pop        = xfer && !fifo_empty;
    assign bypass     = xfer && fifo_empty;
    assign push       = push_len || (rd_pending && !bypass);

    // A slot is reserved for every read in flight, so returning data always fits.
    assign payload_rd = (state == S_PAYLOAD) && (remaining != '0) &&
                        ((32'(fifo_cnt) + 32'(rd_pending)) < 32'(FIFO_DEPTH));

    assign mem_en_o   = (state == S_LEN_RD) || payload_rd;
    assign mem_addr_o = addr_ptr;

    always_comb begin
        src_data_o = '0;
        if (!fifo_empty) begin
            src_data_o = fifo_mem[rd_ptr];
        end else if (rd_pending) begin
            src_data_o = mem_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_data_i;
        end
    end

`ifdef INJ_STREAM_SRC_CHECKSUM_EN
    logic [31:0] csum_q;
    assign csum_o = csum_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            addr_ptr   <= '0;
            remaining  <= '0;
            rd_pending <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            flit_cnt_o <= '0;
`ifdef INJ_STREAM_SRC_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            done_o     <= 1'b0;
            rd_pending <= payload_rd;

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + CNT_W'(1);
            end else if (pop && !push) begin
                fifo_cnt <= fifo_cnt - CNT_W'(1);
            end
            if (xfer) begin
                flit_cnt_o <= flit_cnt_o + 32'd1;
`ifdef INJ_STREAM_SRC_CHECKSUM_EN
                csum_q     <= csum_q ^ src_data_o;
`endif
            end

            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state      <= S_LEN_RD;
                        addr_ptr   <= base_addr_i;
                        busy_o     <= 1'b1;
                        err_o      <= 1'b0;
                        flit_cnt_o <= '0;
`ifdef INJ_STREAM_SRC_CHECKSUM_EN
                        csum_q     <= '0;
`endif
                    end
                end
                S_LEN_RD: begin
                    addr_ptr <= addr_ptr + ADDR_W'(1);
                    state    <= S_LEN_WAIT;
                end
                S_LEN_WAIT: begin
                    if (len_zero) begin
                        state <= S_DRAIN;
                    end else if (len_bad) begin
                        // Drop anything still queued from earlier packets.
                        state    <= S_ERR;
                        err_o    <= 1'b1;
                        busy_o   <= 1'b0;
                        wr_ptr   <= '0;
                        rd_ptr   <= '0;
                        fifo_cnt <= '0;
                    end else begin
                        remaining <= REM_W'(mem_data_i);
                        state     <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (payload_rd) begin
                        addr_ptr  <= addr_ptr + ADDR_W'(1);
                        remaining <= remaining - REM_W'(1);
                    end else if ((remaining == '0) && !rd_pending &&
                                 (32'(fifo_cnt) < 32'(FIFO_DEPTH))) begin
                        state <= S_LEN_RD;
                    end
                end
                S_DRAIN: begin
                    if (fifo_empty) begin
                        state  <= S_IDLE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                S_ERR: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
